// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and constants for the DES S-box scheduler
package des_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sbox_sched_state_t;

    localparam int DES_SBOX_COUNT = 8;
    localparam int DES_SBOX_IN_W  = 6;
    localparam int DES_SBOX_OUT_W = 4;
endpackage

// File: rtl/des_sbox_bank.sv
// rtl/des_sbox_bank.sv - combinational bank routing BOXES_PER_CYCLE lanes to the S-boxes at base..base+N-1
module des_sbox_bank
    import des_pkg::*;
#(
    parameter int BOXES_PER_CYCLE = 1
) (
    input  logic [BOXES_PER_CYCLE*DES_SBOX_IN_W-1:0]  addr,
    input  logic [2:0]                                base,
    output logic [BOXES_PER_CYCLE*DES_SBOX_OUT_W-1:0] nib
);
    logic [DES_SBOX_IN_W-1:0]  box_addr [DES_SBOX_COUNT];
    logic [DES_SBOX_OUT_W-1:0] box_out  [DES_SBOX_COUNT];

    // base is always a multiple of BOXES_PER_CYCLE, so box k is always served by lane k mod N
    for (genvar k = 0; k < DES_SBOX_COUNT; k++) begin : g_route
        assign box_addr[k] = addr[(k % BOXES_PER_CYCLE)*DES_SBOX_IN_W +: DES_SBOX_IN_W];
    end

    S_Box_1 u_s1 (.addr(box_addr[0]), .dout(box_out[0]));
    S_Box_2 u_s2 (.addr(box_addr[1]), .dout(box_out[1]));
    S_Box_3 u_s3 (.addr(box_addr[2]), .dout(box_out[2]));
    S_Box_4 u_s4 (.addr(box_addr[3]), .dout(box_out[3]));
    S_Box_5 u_s5 (.addr(box_addr[4]), .dout(box_out[4]));
    S_Box_6 u_s6 (.addr(box_addr[5]), .dout(box_out[5]));
    S_Box_7 u_s7 (.addr(box_addr[6]), .dout(box_out[6]));
    S_Box_8 u_s8 (.addr(box_addr[7]), .dout(box_out[7]));

    always_comb begin
        nib = '0;
        for (int j = 0; j < BOXES_PER_CYCLE; j++) begin
            nib[j*DES_SBOX_OUT_W +: DES_SBOX_OUT_W] = box_out[base + 3'(j)];
        end
    end
endmodule

// File: rtl/des_sboxes.sv
// rtl/des_sboxes.sv - the eight DES S-boxes as row-major 64-nibble lookup tables
module des_sbox_lut #(
    parameter logic [255:0] TABLE = '0
) (
    input  logic [5:0] addr,
    output logic [3:0] dout
);
    // row = outer bits {b5,b0}, column = inner bits b4..b1; entry 0 sits at the MSB nibble
    logic [5:0] entry;
    assign entry = {addr[5], addr[0], addr[4:1]};
    assign dout  = TABLE[4*(63-int'(entry)) +: 4];
endmodule

module S_Box_1 (input logic [5:0] addr, output logic [3:0] dout);
    des_sbox_lut #(.TABLE(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D))
        u_lut (.addr(addr), .dout(dout));
endmodule

module S_Box_2 (input logic [5:0] addr, output logic [3:0] dout);
    des_sbox_lut #(.TABLE(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9))
        u_lut (.addr(addr), .dout(dout));
endmodule

module S_Box_3 (input logic [5:0] addr, output logic [3:0] dout);
    des_sbox_lut #(.TABLE(256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C))
        u_lut (.addr(addr), .dout(dout));
endmodule

module S_Box_4 (input logic [5:0] addr, output logic [3:0] dout);
    des_sbox_lut #(.TABLE(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E))
        u_lut (.addr(addr), .dout(dout));
endmodule

module S_Box_5 (input logic [5:0] addr, output logic [3:0] dout);
    des_sbox_lut #(.TABLE(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453))
        u_lut (.addr(addr), .dout(dout));
endmodule

module S_Box_6 (input logic [5:0] addr, output logic [3:0] dout);
    des_sbox_lut #(.TABLE(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D))
        u_lut (.addr(addr), .dout(dout));
endmodule

module S_Box_7 (input logic [5:0] addr, output logic [3:0] dout);
    des_sbox_lut #(.TABLE(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C))
        u_lut (.addr(addr), .dout(dout));
endmodule

module S_Box_8 (input logic [5:0] addr, output logic [3:0] dout);
    des_sbox_lut #(.TABLE(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B))
        u_lut (.addr(addr), .dout(dout));
endmodule

// File: rtl/des_sbox_scheduler.sv
// rtl/des_sbox_scheduler.sv - time-multiplexed DES S-box substitution with valid/ready handshake
module des_sbox_scheduler
    import des_pkg::*;
#(
    parameter int BOXES_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    input  logic        abort,
    output logic        busy
);
    if (!(BOXES_PER_CYCLE inside {1, 2, 4, 8})) begin : g_bad_bpc
        $error("des_sbox_scheduler: BOXES_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [2:0] IDX_STEP = 3'(BOXES_PER_CYCLE % DES_SBOX_COUNT);
    localparam logic [2:0] LAST_IDX = 3'(DES_SBOX_COUNT - BOXES_PER_CYCLE);

    sbox_sched_state_t state, state_next;
    logic [2:0]  idx;
    logic [47:0] data_q;
    logic [31:0] result;
    logic        accept;
    logic [BOXES_PER_CYCLE*DES_SBOX_IN_W-1:0]  lane_addr;
    logic [BOXES_PER_CYCLE*DES_SBOX_OUT_W-1:0] lane_nib;

    assign accept = (state == IDLE) && in_valid && !abort;

    always_comb begin
        lane_addr = '0;
        for (int j = 0; j < BOXES_PER_CYCLE; j++) begin
            lane_addr[j*DES_SBOX_IN_W +: DES_SBOX_IN_W] = data_q[47 - DES_SBOX_IN_W*(int'(idx)+j) -: DES_SBOX_IN_W];
        end
    end

    des_sbox_bank #(.BOXES_PER_CYCLE(BOXES_PER_CYCLE)) u_bank (
        .addr (lane_addr),
        .base (idx),
        .nib  (lane_nib)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN: begin
                if (abort)                 state_next = IDLE;
                else if (idx == LAST_IDX)  state_next = DONE;
            end
            DONE: if (abort || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            data_q <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                data_q <= in_data;
                idx    <= '0;
                result <= '0;
            end else if (state == RUN && !abort) begin
                // idx wraps to 0 naturally on the final RUN step
                idx <= idx + IDX_STEP;
                for (int j = 0; j < BOXES_PER_CYCLE; j++) begin
                    result[31 - DES_SBOX_OUT_W*(int'(idx)+j) -: DES_SBOX_OUT_W] <= lane_nib[j*DES_SBOX_OUT_W +: DES_SBOX_OUT_W];
                end
            end else if (abort) begin
                idx <= '0;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = result;
endmodule

// File: tb/tb_des_sbox_scheduler.sv
// tb/tb_des_sbox_scheduler.sv - directed self-checking bench for des_sbox_scheduler
module tb_des_sbox_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, abort, busy;
    logic [47:0] in_data;
    logic [31:0] out_data;
    logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_abort, w8_busy;
    logic [47:0] w8_in_data;
    logic [31:0] w8_out_data;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    des_sbox_scheduler #(.BOXES_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .abort(abort), .busy(busy)
    );

    des_sbox_scheduler #(.BOXES_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_data(w8_in_data),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_data(w8_out_data), .abort(w8_abort), .busy(w8_busy)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_wait(input logic [47:0] d, output int lat);
        check("in_ready_before_accept", in_ready, 1);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_word(input string tag, input logic [47:0] d, input logic [31:0] exp);
        int lat;
        send_and_wait(d, lat);
        check({tag, "_latency"}, lat, 9);
        check({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int          lat;
        int          acc [3];
        logic [31:0] snap;
        logic        ok, seen;
        logic [47:0] b2b_in  [3];
        logic [31:0] b2b_exp [3];
        logic [47:0] v8_in   [2];
        logic [31:0] v8_exp  [2];

        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; abort = 0; in_data = '0;
        w8_in_valid = 0; w8_out_ready = 0; w8_abort = 0; w8_in_data = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst8_in_ready", w8_in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 8-boxes-per-cycle instance: all-ones and all-zeros
        v8_in[0] = 48'hFFFF_FFFF_FFFF; v8_exp[0] = 32'hD9CE3DCB;
        v8_in[1] = 48'h0;              v8_exp[1] = 32'hEFA72C4D;
        for (int v = 0; v < 2; v++) begin
            w8_in_data  = v8_in[v];
            w8_in_valid = 1'b1;
            tick();
            w8_in_valid = 1'b0;
            lat = 1;
            while (!w8_out_valid && lat < 40) begin
                tick();
                lat++;
            end
            check("bpc8_latency", lat, 2);
            check("bpc8_data", w8_out_data, v8_exp[v]);
            w8_out_ready = 1'b1;
            tick();
            w8_out_ready = 1'b0;
            check("bpc8_in_ready_after", w8_in_ready, 1);
        end

        run_word("zeros", 48'h0, 32'hEFA72C4D);
        run_word("ones", 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
        run_word("s3_iso", 48'h0000_4000_0000, 32'hEFD72C4D);
        run_word("s1_iso", 48'hFC00_0000_0000, 32'hDFA72C4D);
        run_word("s8_iso", 48'h0000_0000_0001, 32'hEFA72C41);

        // backpressure
        send_and_wait(48'h0, lat);
        snap = out_data;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (!(out_valid === 1'b1 && out_data === snap && in_ready === 1'b0 && busy === 1'b1)) ok = 1'b0;
        end
        check("bp_hold_stable", ok, 1);
        check("bp_data", out_data, 32'hEFA72C4D);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);

        // abort in the third RUN cycle
        in_data = 48'hFFFF_FFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_run_busy", busy, 0);
        check("abort_run_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_run_no_output", seen, 0);
        run_word("after_abort", 48'h0000_4000_0000, 32'hEFD72C4D);

        // abort in IDLE blocks acceptance
        in_valid = 1'b1;
        abort = 1'b1;
        tick();
        in_valid = 1'b0;
        abort = 1'b0;
        check("abort_idle_no_accept", busy, 0);

        // abort in DONE with out_ready high
        send_and_wait(48'hFFFF_FFFF_FFFF, lat);
        out_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_done_valid", out_valid, 0);
        check("abort_done_busy", busy, 0);
        run_word("after_abort_done", 48'h0, 32'hEFA72C4D);

        // asynchronous reset mid-RUN
        in_data = 48'hFFFF_FFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out_data", out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("arst_no_output", seen, 0);

        // back-to-back words with out_ready held high
        b2b_in[0] = 48'h0;              b2b_exp[0] = 32'hEFA72C4D;
        b2b_in[1] = 48'hFFFF_FFFF_FFFF; b2b_exp[1] = 32'hD9CE3DCB;
        b2b_in[2] = 48'hFC00_0000_0000; b2b_exp[2] = 32'hDFA72C4D;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            in_data = b2b_in[w];
            lat = 0;
            while (!in_ready && lat < 40) begin
                tick();
                lat++;
            end
            acc[w] = cyc;
            tick();
            lat = 1;
            while (!out_valid && lat < 40) begin
                tick();
                lat++;
            end
            check("b2b_data", out_data, b2b_exp[w]);
        end
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        check("b2b_interval_1", acc[1] - acc[0], 10);
        check("b2b_interval_2", acc[2] - acc[1], 10);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
